// File: rtl/id_ex_stage.sv
// id_ex_stage
//
// ID/EX pipeline register for the pipelined RV32I core, with the load-use
// hazard detector. Captures the decode-stage control bundle, operands and
// register indices and presents them to EX one cycle later.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   *_id                  decode-stage control bundle, funct fields, register
//                         indices, operands, immediate and PC
//   flush_i               branch/jump resolved taken in EX: kill the ID instruction
//   hold_i                global freeze, every register keeps its value
//   stall_o               combinational: freeze PC and IF/ID this cycle
//   *_ex                  registered copy of every *_id input
//   valid_ex              EX slot holds a real instruction (0 = bubble)
//
// Control fields (regwrite, memread, memwrite, branch, memtoreg, alusrc,
// auipc, aluop, valid) clear on a bubble. Data fields are loaded even on a
// bubble since they are don't-care while valid_ex is 0.

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 9
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [6:0]        opcode_id,
  input  logic              alusrc_id,
  input  logic              memtoreg_id,
  input  logic              regwrite_id,
  input  logic              memread_id,
  input  logic              memwrite_id,
  input  logic              branch_id,
  input  logic              auipc_id,
  input  logic [2:0]        aluop_id,
  input  logic [2:0]        funct3_id,
  input  logic [6:0]        funct7_id,
  input  logic [4:0]        rs1_id,
  input  logic [4:0]        rs2_id,
  input  logic [4:0]        rd_id,
  input  logic [DATA_W-1:0] rd1_id,
  input  logic [DATA_W-1:0] rd2_id,
  input  logic [DATA_W-1:0] imm_id,
  input  logic [PC_W-1:0]   pc_id,

  input  logic              flush_i,
  input  logic              hold_i,
  output logic              stall_o,

  output logic [6:0]        opcode_ex,
  output logic              alusrc_ex,
  output logic              memtoreg_ex,
  output logic              regwrite_ex,
  output logic              memread_ex,
  output logic              memwrite_ex,
  output logic              branch_ex,
  output logic              auipc_ex,
  output logic [2:0]        aluop_ex,
  output logic [2:0]        funct3_ex,
  output logic [6:0]        funct7_ex,
  output logic [4:0]        rs1_ex,
  output logic [4:0]        rs2_ex,
  output logic [4:0]        rd_ex,
  output logic [DATA_W-1:0] rd1_ex,
  output logic [DATA_W-1:0] rd2_ex,
  output logic [DATA_W-1:0] imm_ex,
  output logic [PC_W-1:0]   pc_ex,
  output logic              valid_ex
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic rs1_used;
  logic rs2_used;
  logic rs1_match;
  logic rs2_match;
  logic hazard;
  logic load_bubble;
  logic load_data;

  // Which source fields of the ID instruction are real register reads.
  // Unused fields hold immediate bits and must not raise a false stall.
  always_comb begin
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opcode_id)
      OP_JAL, OP_LUI, OP_AUIPC:  rs1_used = 1'b0;
      OP_R, OP_STORE, OP_BRANCH: rs2_used = 1'b1;
      default: ;
    endcase
  end

  assign rs1_match = rs1_used && (rs1_id == rd_ex);
  assign rs2_match = rs2_used && (rs2_id == rd_ex);

  // A load into x0 produces nothing to forward, so it never stalls.
  assign hazard = valid_ex && memread_ex && (rd_ex != 5'd0) &&
                  (rs1_match || rs2_match);

  // Flush wins over both hold and hazard; under hold the upstream is already
  // frozen and the hazard is re-evaluated once the hold releases.
  assign stall_o = hazard && !flush_i && !hold_i;

  assign load_bubble = flush_i || (!hold_i && hazard);
  assign load_data   = flush_i || !hold_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_ex   <= '0;
      alusrc_ex   <= 1'b0;
      memtoreg_ex <= 1'b0;
      regwrite_ex <= 1'b0;
      memread_ex  <= 1'b0;
      memwrite_ex <= 1'b0;
      branch_ex   <= 1'b0;
      auipc_ex    <= 1'b0;
      aluop_ex    <= '0;
      funct3_ex   <= '0;
      funct7_ex   <= '0;
      rs1_ex      <= '0;
      rs2_ex      <= '0;
      rd_ex       <= '0;
      rd1_ex      <= '0;
      rd2_ex      <= '0;
      imm_ex      <= '0;
      pc_ex       <= '0;
      valid_ex    <= 1'b0;
    end else begin
      if (load_data) begin
        opcode_ex <= opcode_id;
        funct3_ex <= funct3_id;
        funct7_ex <= funct7_id;
        rs1_ex    <= rs1_id;
        rs2_ex    <= rs2_id;
        rd_ex     <= rd_id;
        rd1_ex    <= rd1_id;
        rd2_ex    <= rd2_id;
        imm_ex    <= imm_id;
        pc_ex     <= pc_id;
      end

      if (load_bubble) begin
        alusrc_ex   <= 1'b0;
        memtoreg_ex <= 1'b0;
        regwrite_ex <= 1'b0;
        memread_ex  <= 1'b0;
        memwrite_ex <= 1'b0;
        branch_ex   <= 1'b0;
        auipc_ex    <= 1'b0;
        aluop_ex    <= '0;
        valid_ex    <= 1'b0;
      end else if (!hold_i) begin
        alusrc_ex   <= alusrc_id;
        memtoreg_ex <= memtoreg_id;
        regwrite_ex <= regwrite_id;
        memread_ex  <= memread_id;
        memwrite_ex <= memwrite_id;
        branch_ex   <= branch_id;
        auipc_ex    <= auipc_id;
        aluop_ex    <= aluop_id;
        valid_ex    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
//
// Directed and randomized bench for id_ex_stage. A behavioural model keeps
// the expected EX-slot contents as one bundle and applies the update rules
// (reset, flush, hold, load-use bubble, normal load) once per edge.

module tb_id_ex_stage;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef struct packed {
    logic [6:0]  opcode;
    logic        alusrc;
    logic        memtoreg;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic        auipc;
    logic [2:0]  aluop;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [8:0]  pc;
  } bundle_t;

  logic    clk;
  logic    rst;
  logic    flush;
  logic    hold;
  bundle_t id;
  bundle_t obs;
  logic    stall_o;

  logic [6:0]  opcode_ex;
  logic        alusrc_ex, memtoreg_ex, regwrite_ex, memread_ex;
  logic        memwrite_ex, branch_ex, auipc_ex, valid_ex;
  logic [2:0]  aluop_ex, funct3_ex;
  logic [6:0]  funct7_ex;
  logic [4:0]  rs1_ex, rs2_ex, rd_ex;
  logic [31:0] rd1_ex, rd2_ex, imm_ex;
  logic [8:0]  pc_ex;

  bundle_t m_ex;
  logic    m_valid;
  bundle_t snap;

  int total = 0;
  int bad   = 0;

  id_ex_stage #(.DATA_W(32), .PC_W(9)) dut (
    .clk         (clk),
    .reset       (rst),
    .opcode_id   (id.opcode),
    .alusrc_id   (id.alusrc),
    .memtoreg_id (id.memtoreg),
    .regwrite_id (id.regwrite),
    .memread_id  (id.memread),
    .memwrite_id (id.memwrite),
    .branch_id   (id.branch),
    .auipc_id    (id.auipc),
    .aluop_id    (id.aluop),
    .funct3_id   (id.funct3),
    .funct7_id   (id.funct7),
    .rs1_id      (id.rs1),
    .rs2_id      (id.rs2),
    .rd_id       (id.rd),
    .rd1_id      (id.rd1),
    .rd2_id      (id.rd2),
    .imm_id      (id.imm),
    .pc_id       (id.pc),
    .flush_i     (flush),
    .hold_i      (hold),
    .stall_o     (stall_o),
    .opcode_ex   (opcode_ex),
    .alusrc_ex   (alusrc_ex),
    .memtoreg_ex (memtoreg_ex),
    .regwrite_ex (regwrite_ex),
    .memread_ex  (memread_ex),
    .memwrite_ex (memwrite_ex),
    .branch_ex   (branch_ex),
    .auipc_ex    (auipc_ex),
    .aluop_ex    (aluop_ex),
    .funct3_ex   (funct3_ex),
    .funct7_ex   (funct7_ex),
    .rs1_ex      (rs1_ex),
    .rs2_ex      (rs2_ex),
    .rd_ex       (rd_ex),
    .rd1_ex      (rd1_ex),
    .rd2_ex      (rd2_ex),
    .imm_ex      (imm_ex),
    .pc_ex       (pc_ex),
    .valid_ex    (valid_ex)
  );

  assign obs = {opcode_ex, alusrc_ex, memtoreg_ex, regwrite_ex, memread_ex,
                memwrite_ex, branch_ex, auipc_ex, aluop_ex, funct3_ex,
                funct7_ex, rs1_ex, rs2_ex, rd_ex, rd1_ex, rd2_ex, imm_ex, pc_ex};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [159:0] o, input logic [159:0] e);
    total++;
    assert (o === e)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic bundle_t bubble(input bundle_t b);
    bundle_t r = b;
    r.alusrc   = 1'b0;
    r.memtoreg = 1'b0;
    r.regwrite = 1'b0;
    r.memread  = 1'b0;
    r.memwrite = 1'b0;
    r.branch   = 1'b0;
    r.auipc    = 1'b0;
    r.aluop    = 3'd0;
    return r;
  endfunction

  // Load-use rule stated directly: a valid load in EX writing a nonzero
  // register that the ID instruction actually reads.
  function automatic logic model_hazard();
    logic reads_rs1, reads_rs2;
    reads_rs1 = !(id.opcode inside {OP_JAL, OP_LUI, OP_AUIPC});
    reads_rs2 =  (id.opcode inside {OP_R, OP_STORE, OP_BR});
    return m_valid && m_ex.memread && (m_ex.rd != 5'd0) &&
           ((reads_rs1 && id.rs1 == m_ex.rd) || (reads_rs2 && id.rs2 == m_ex.rd));
  endfunction

  function automatic bundle_t rnd_instr();
    bundle_t b;
    logic [6:0] ops [9] = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BR,
                            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    b.opcode   = ops[$urandom_range(0, 8)];
    b.alusrc   = 1'($urandom);
    b.memtoreg = (b.opcode == OP_LOAD);
    b.regwrite = !(b.opcode inside {OP_STORE, OP_BR});
    b.memread  = (b.opcode == OP_LOAD);
    b.memwrite = (b.opcode == OP_STORE);
    b.branch   = (b.opcode == OP_BR);
    b.auipc    = (b.opcode == OP_AUIPC);
    b.aluop    = 3'($urandom_range(1, 7));
    b.funct3   = 3'($urandom);
    b.funct7   = 7'($urandom);
    b.rs1      = 5'($urandom_range(0, 3));
    b.rs2      = 5'($urandom_range(0, 3));
    b.rd       = 5'($urandom_range(0, 3));
    b.rd1      = $urandom;
    b.rd2      = $urandom;
    b.imm      = $urandom;
    b.pc       = 9'($urandom);
    return b;
  endfunction

  function automatic bundle_t ins(input logic [6:0] op, input logic [4:0] r1,
                                  input logic [4:0] r2, input logic [4:0] d);
    bundle_t b = rnd_instr();
    b.opcode   = op;
    b.rs1      = r1;
    b.rs2      = r2;
    b.rd       = d;
    b.memtoreg = (op == OP_LOAD);
    b.regwrite = !(op inside {OP_STORE, OP_BR});
    b.memread  = (op == OP_LOAD);
    b.memwrite = (op == OP_STORE);
    b.branch   = (op == OP_BR);
    b.auipc    = (op == OP_AUIPC);
    return b;
  endfunction

  // One clock: check stall_o against the model before the edge, advance the
  // model at the edge, then compare every EX output after it.
  task automatic tick(input string tag);
    logic hz;
    #1;
    hz = model_hazard();
    chk({tag, "_stall"}, stall_o, hz && !flush && !hold);
    @(posedge clk);
    if (rst) begin
      m_ex    = '0;
      m_valid = 1'b0;
    end else if (flush) begin
      m_ex    = bubble(id);
      m_valid = 1'b0;
    end else if (hold) begin
      m_ex    = m_ex;
    end else if (hz) begin
      m_ex    = bubble(id);
      m_valid = 1'b0;
    end else begin
      m_ex    = id;
      m_valid = 1'b1;
    end
    #1;
    chk({tag, "_ex"}, obs, m_ex);
    chk({tag, "_valid"}, valid_ex, m_valid);
    @(negedge clk);
  endtask

  task automatic place_load(input logic [4:0] d);
    id = ins(OP_LOAD, 5'd1, 5'd0, d);
    tick("place_lw");
  endtask

  task automatic probe(input string tag, input bundle_t b, input logic exp_stall);
    id = b;
    #1;
    chk(tag, stall_o, exp_stall);
    tick(tag);
  endtask

  initial begin
    m_ex    = '0;
    m_valid = 1'b0;
    rst     = 1'b1;
    flush   = 1'b0;
    hold    = 1'b1;
    id      = '1;

    // Reset with every input nonzero, including hold.
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("reset_ex", obs, '0);
    chk("reset_valid", valid_ex, 1'b0);
    chk("reset_stall", stall_o, 1'b0);
    @(negedge clk);
    hold  = 1'b0;
    flush = 1'b1;
    tick("reset_flush");
    chk("reset_stall_low", stall_o, 1'b0);
    rst   = 1'b0;
    flush = 1'b0;

    // Pass-through: ADDI x5,x0,7 at pc 0x04.
    id          = ins(OP_IMM, 5'd0, 5'd0, 5'd5);
    id.imm      = 32'd7;
    id.pc       = 9'h004;
    id.regwrite = 1'b1;
    tick("addi");
    chk("addi_valid", valid_ex, 1'b1);
    chk("addi_regwrite", regwrite_ex, 1'b1);
    chk("addi_imm", imm_ex, 32'd7);
    chk("addi_rd", rd_ex, 5'd5);
    chk("addi_pc", pc_ex, 9'h004);

    // Load-use: LW x6,0(x1) then ADD x7,x6,x2.
    place_load(5'd6);
    probe("lu_stall", ins(OP_R, 5'd6, 5'd2, 5'd7), 1'b1);
    chk("lu_bubble_valid", valid_ex, 1'b0);
    chk("lu_bubble_ctrl",
        {alusrc_ex, memtoreg_ex, regwrite_ex, memread_ex, memwrite_ex,
         branch_ex, auipc_ex, aluop_ex}, '0);
    #1;
    chk("lu_release", stall_o, 1'b0);
    tick("lu_add");
    chk("lu_add_valid", valid_ex, 1'b1);
    chk("lu_add_rs1", rs1_ex, 5'd6);

    // False-stall screening with LW x6 in EX.
    place_load(5'd6);
    probe("sw_rs2", ins(OP_STORE, 5'd1, 5'd6, 5'd0), 1'b1);
    place_load(5'd6);
    probe("lui", ins(OP_LUI, 5'd6, 5'd6, 5'd6), 1'b0);
    place_load(5'd6);
    probe("auipc", ins(OP_AUIPC, 5'd6, 5'd6, 5'd6), 1'b0);
    place_load(5'd6);
    probe("jal", ins(OP_JAL, 5'd6, 5'd6, 5'd1), 1'b0);
    place_load(5'd6);
    probe("addi_rs2", ins(OP_IMM, 5'd1, 5'd6, 5'd3), 1'b0);
    place_load(5'd6);
    probe("br_rs2", ins(OP_BR, 5'd2, 5'd6, 5'd0), 1'b1);
    place_load(5'd0);
    probe("lw_x0_rs1_6", ins(OP_R, 5'd6, 5'd2, 5'd7), 1'b0);
    place_load(5'd0);
    probe("lw_x0_rs1_0", ins(OP_R, 5'd0, 5'd0, 5'd7), 1'b0);

    // Flush coinciding with a load-use hazard.
    place_load(5'd6);
    flush = 1'b1;
    probe("flush_hz", ins(OP_STORE, 5'd6, 5'd6, 5'd0), 1'b0);
    chk("flush_valid", valid_ex, 1'b0);
    chk("flush_regwrite", regwrite_ex, 1'b0);
    chk("flush_memwrite", memwrite_ex, 1'b0);
    flush = 1'b0;

    // Hold for three cycles with changing ID inputs and a live hazard.
    place_load(5'd6);
    snap = m_ex;
    hold = 1'b1;
    probe("hold_hz", ins(OP_R, 5'd6, 5'd6, 5'd9), 1'b0);
    chk("hold1_const", obs, snap);
    id = rnd_instr();
    tick("hold2");
    chk("hold2_const", obs, snap);
    id = rnd_instr();
    tick("hold3");
    chk("hold3_const", obs, snap);
    hold = 1'b0;
    id   = ins(OP_IMM, 5'd2, 5'd0, 5'd4);
    tick("hold_release");
    chk("hold_release_rd", rd_ex, 5'd4);
    chk("hold_release_valid", valid_ex, 1'b1);

    // Reset mid-stream overrides flush and hold.
    rst   = 1'b1;
    flush = 1'b1;
    hold  = 1'b1;
    tick("mid_reset");
    chk("mid_reset_ex", obs, '0);
    rst   = 1'b0;
    flush = 1'b0;
    hold  = 1'b0;

    // Randomized traffic with small register indices to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      id    = rnd_instr();
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
